// File: rtl/conv_stream_feeder.sv
// Buffers one ROWS-entry row/kernel pattern, replays it to the engine as a GAP-delayed burst, then forwards NUM_OUT results.
// All outputs are registered one cycle after the causing edge; ld_ready gates loading, and the result port has no back-pressure.
module conv_stream_feeder #(
    parameter int ROWS    = 6,
    parameter int ROW_W   = 18,
    parameter int KER_W   = 12,
    parameter int NUM_OUT = 150,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                       clk1,
    input  logic                       rst,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [ROW_W-1:0]           ld_row,
    input  logic [KER_W-1:0]           ld_kernel,
    output logic                       in_valid,
    output logic [ROW_W-1:0]           in_row,
    output logic [KER_W-1:0]           in_kernel,
    input  logic                       out_valid,
    input  logic [7:0]                 out_data,
    output logic                       res_valid,
    output logic [7:0]                 res_data,
    output logic [$clog2(NUM_OUT)-1:0] res_idx,
    output logic                       done,
    output logic                       timeout,
    output logic                       stray,
    output logic                       busy
);
    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int RW = $clog2(NUM_OUT);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW-1:0] ROW_LAST = AW'(ROWS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [RW-1:0] RES_LAST = RW'(NUM_OUT - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_LOAD, S_GAP, S_SEND, S_WAIT} state_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [KER_W-1:0] kernel;
    } entry_t;

    entry_t          entry_mem [ROWS];
    state_t          state, state_d;
    logic [AW-1:0]   wcnt, wcnt_d, scnt, scnt_d;
    logic [GW-1:0]   gcnt, gcnt_d;
    logic [RW-1:0]   rcnt, rcnt_d, res_idx_d;
    logic [TW-1:0]   timer, timer_d;
    logic            ld_accept;
    logic            ld_ready_d, in_valid_d, res_valid_d, done_d, timeout_d, stray_d, busy_d;
    logic [ROW_W-1:0] in_row_d;
    logic [KER_W-1:0] in_kernel_d;
    logic [7:0]      res_data_d;

    assign ld_accept = ld_valid && ld_ready;

    always_comb begin
        state_d     = state;
        wcnt_d      = wcnt;
        gcnt_d      = gcnt;
        scnt_d      = scnt;
        rcnt_d      = rcnt;
        timer_d     = timer;
        in_valid_d  = 1'b0;
        in_row_d    = '0;
        in_kernel_d = '0;
        res_valid_d = 1'b0;
        res_data_d  = res_data;
        res_idx_d   = res_idx;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        stray_d     = out_valid && (state != S_WAIT);
        case (state)
            S_LOAD: begin
                if (ld_accept) begin
                    if (wcnt == ROW_LAST) begin
                        state_d = S_GAP;
                        gcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_d     = S_SEND;
                    scnt_d      = '0;
                    in_valid_d  = 1'b1;
                    in_row_d    = entry_mem[0].row;
                    in_kernel_d = entry_mem[0].kernel;
                end else begin
                    gcnt_d = gcnt + 1'b1;
                end
            end
            S_SEND: begin
                // scnt is the row currently on the bus; the next one is staged here
                if (scnt == ROW_LAST) begin
                    state_d = S_WAIT;
                    rcnt_d  = '0;
                    timer_d = '0;
                end else begin
                    scnt_d      = scnt + 1'b1;
                    in_valid_d  = 1'b1;
                    in_row_d    = entry_mem[scnt_d].row;
                    in_kernel_d = entry_mem[scnt_d].kernel;
                end
            end
            S_WAIT: begin
                if (out_valid) begin
                    res_valid_d = 1'b1;
                    res_data_d  = out_data;
                    res_idx_d   = rcnt;
                    timer_d     = '0;
                    if (rcnt == RES_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_LOAD;
                        wcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt + 1'b1;
                    end
                end else if (timer == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_LOAD;
                    wcnt_d    = '0;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            default: state_d = S_LOAD;
        endcase
        // Re-entry into LOAD exposes ld_ready one cycle late; the last accept drops it at once
        ld_ready_d = (state == S_LOAD) && (state_d == S_LOAD);
        busy_d     = (state_d != S_LOAD);
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state     <= S_LOAD;
            wcnt      <= '0;
            gcnt      <= '0;
            scnt      <= '0;
            rcnt      <= '0;
            timer     <= '0;
            ld_ready  <= 1'b1;
            in_valid  <= 1'b0;
            in_row    <= '0;
            in_kernel <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            stray     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            wcnt      <= wcnt_d;
            gcnt      <= gcnt_d;
            scnt      <= scnt_d;
            rcnt      <= rcnt_d;
            timer     <= timer_d;
            ld_ready  <= ld_ready_d;
            in_valid  <= in_valid_d;
            in_row    <= in_row_d;
            in_kernel <= in_kernel_d;
            res_valid <= res_valid_d;
            res_data  <= res_data_d;
            res_idx   <= res_idx_d;
            done      <= done_d;
            timeout   <= timeout_d;
            stray     <= stray_d;
            busy      <= busy_d;
        end
    end

    always_ff @(posedge clk1) begin
        if (ld_accept) begin
            entry_mem[wcnt] <= '{row: ld_row, kernel: ld_kernel};
        end
    end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Bench for conv_stream_feeder: loads random patterns, checks burst timing/data, result forwarding,
// timeout, stray pulses and mid-burst reset against an expected-behaviour model kept here.
module tb_conv_stream_feeder;
    localparam int ROWS    = 6;
    localparam int ROW_W   = 18;
    localparam int KER_W   = 12;
    localparam int NUM_OUT = 150;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 4096;
    localparam int IW      = $clog2(NUM_OUT);

    logic             clk1 = 1'b0;
    logic             rst = 1'b1;
    logic             ld_valid = 1'b0;
    logic             ld_ready;
    logic [ROW_W-1:0] ld_row = '0;
    logic [KER_W-1:0] ld_kernel = '0;
    logic             in_valid;
    logic [ROW_W-1:0] in_row;
    logic [KER_W-1:0] in_kernel;
    logic             out_valid = 1'b0;
    logic [7:0]       out_data = '0;
    logic             res_valid;
    logic [7:0]       res_data;
    logic [IW-1:0]    res_idx;
    logic             done, timeout, stray, busy;

    int errors = 0;
    int checks = 0;
    logic [ROW_W-1:0] pat_row [ROWS];
    logic [KER_W-1:0] pat_ker [ROWS];

    always #5 clk1 = ~clk1;

    conv_stream_feeder #(
        .ROWS(ROWS), .ROW_W(ROW_W), .KER_W(KER_W),
        .NUM_OUT(NUM_OUT), .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk1(clk1), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_row(ld_row), .ld_kernel(ld_kernel),
        .in_valid(in_valid), .in_row(in_row), .in_kernel(in_kernel),
        .out_valid(out_valid), .out_data(out_data),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
        .done(done), .timeout(timeout), .stray(stray), .busy(busy)
    );

    task automatic wait_ready();
        int c = 0;
        while (ld_ready !== 1'b1 && c < 16) begin
            @(negedge clk1);
            c++;
        end
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: ld_ready=%b after %0d cycles, want 1", ld_ready, c);
        end
    endtask

    // Loads ROWS entries, then checks every cycle from the last accept edge t (k=0) through the burst.
    task automatic load_and_burst(input bit fixed, input bit toggle, input int stray_k, input int rst_k);
        int n = 0;
        for (int i = 0; i < ROWS; i++) begin
            pat_row[i] = fixed ? ROW_W'(i + 1) : ROW_W'($urandom);
            pat_ker[i] = fixed ? KER_W'(12'h101 + i) : KER_W'($urandom);
        end
        for (int c = 0; c < 4 * ROWS && n < ROWS; c++) begin
            ld_valid  = toggle ? (c % 2 == 0) : 1'b1;
            ld_row    = ld_valid ? pat_row[n] : ROW_W'($urandom);
            ld_kernel = ld_valid ? pat_ker[n] : KER_W'($urandom);
            checks++;
            if (ld_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_ready: entry %0d ld_ready=%b want 1", n, ld_ready);
            end
            if (ld_valid) n++;
            @(negedge clk1);
        end
        ld_valid = 1'b0;
        for (int k = 0; k < GAP + ROWS + 2; k++) begin
            bit exp_v;
            int idx;
            logic [ROW_W+KER_W-1:0] exp_d;
            exp_v = (k >= GAP) && (k < GAP + ROWS);
            idx   = exp_v ? k - GAP : 0;
            exp_d = exp_v ? {pat_row[idx], pat_ker[idx]} : '0;
            checks++;
            if (in_valid !== exp_v) begin
                errors++;
                $display("FAIL burst_valid: k=%0d in_valid=%b want %b", k, in_valid, exp_v);
            end
            checks++;
            if ({in_row, in_kernel} !== exp_d) begin
                errors++;
                $display("FAIL burst_data: k=%0d row/kernel=%h want %h", k, {in_row, in_kernel}, exp_d);
            end
            checks++;
            if ({ld_ready, busy, res_valid, stray} !== {2'b01, 1'b0, (stray_k >= 0 && k == stray_k + 1)}) begin
                errors++;
                $display("FAIL burst_flags: k=%0d ld_ready/busy/res_valid/stray=%b", k, {ld_ready, busy, res_valid, stray});
            end
            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                checks++;
                if ({in_valid, ld_ready, busy, res_valid, in_row} !== {4'b0100, {ROW_W{1'b0}}}) begin
                    errors++;
                    $display("FAIL reset_mid_burst: in_valid/ld_ready/busy/res_valid=%b row=%h want 0100 0",
                             {in_valid, ld_ready, busy, res_valid}, in_row);
                end
                @(negedge clk1);
                rst = 1'b0;
                return;
            end
            out_valid = (k == stray_k);
            @(negedge clk1);
        end
        out_valid = 1'b0;
    endtask

    task automatic do_results(input int n, input int tie_at);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (i == tie_at) ? TIMEOUT - 1 : int'($urandom_range(0, 6));
            for (int j = 0; j < g; j++) begin
                out_valid = 1'b0;
                out_data  = 8'($urandom);
                @(negedge clk1);
                checks++;
                if ({res_valid, done, timeout, stray} !== 4'b0000) begin
                    errors++;
                    $display("FAIL result_idle: before idx %0d res_valid/done/timeout/stray=%b want 0000",
                             i, {res_valid, done, timeout, stray});
                end
            end
            out_valid = 1'b1;
            out_data  = 8'(i);
            @(negedge clk1);
            out_valid = 1'b0;
            checks++;
            if ({res_valid, res_data, res_idx, done, timeout, stray} !==
                {1'b1, 8'(i), IW'(i), (i == NUM_OUT - 1), 2'b00}) begin
                errors++;
                $display("FAIL result: idx %0d got v=%b data=%h idx=%0d done=%b tmo=%b stray=%b want data=%h done=%b",
                         i, res_valid, res_data, res_idx, done, timeout, stray, 8'(i), (i == NUM_OUT - 1));
            end
        end
        if (n == NUM_OUT) begin
            checks++;
            if ({busy, ld_ready} !== 2'b00) begin
                errors++;
                $display("FAIL done_cycle: busy/ld_ready=%b want 00", {busy, ld_ready});
            end
            @(negedge clk1);
            checks++;
            if ({busy, ld_ready} !== 2'b01) begin
                errors++;
                $display("FAIL after_done: busy/ld_ready=%b want 01", {busy, ld_ready});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk1);
        checks++;
        if ({ld_ready, in_valid, res_valid, done, timeout, stray, busy} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 1000000", {ld_ready, in_valid, res_valid, done, timeout, stray, busy});
        end
        checks++;
        if ({in_row, in_kernel, res_data, res_idx} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {in_row, in_kernel, res_data, res_idx});
        end
        rst = 1'b0;
        @(negedge clk1);
        checks++;
        if ({ld_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: ld_ready/busy=%b want 10", {ld_ready, busy});
        end
    endtask

    task automatic test_stray_load();
        out_valid = 1'b1;
        out_data  = 8'hA5;
        @(negedge clk1);
        out_valid = 1'b0;
        checks++;
        if ({stray, res_valid, busy, ld_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL stray_load: stray/res_valid/busy/ld_ready=%b want 1001", {stray, res_valid, busy, ld_ready});
        end
        @(negedge clk1);
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL stray_clear: stray=%b want 0", stray);
        end
    endtask

    task automatic test_back_to_back();
        wait_ready();
        load_and_burst(1'b1, 1'b0, -1, -1);
        do_results(NUM_OUT, 75);
    endtask

    task automatic test_toggle_load();
        wait_ready();
        load_and_burst(1'b0, 1'b1, GAP + 2, -1);
        do_results(NUM_OUT, -1);
    endtask

    task automatic test_timeout();
        wait_ready();
        load_and_burst(1'b0, 1'b0, -1, -1);
        do_results(10, -1);
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            @(negedge clk1);
            checks++;
            if ({timeout, done, res_valid} !== {(k == TIMEOUT), 2'b00}) begin
                errors++;
                $display("FAIL timeout_pulse: k=%0d timeout/done/res_valid=%b want %b00",
                         k, {timeout, done, res_valid}, (k == TIMEOUT));
            end
            if (k == TIMEOUT) begin
                checks++;
                if ({busy, ld_ready} !== 2'b00) begin
                    errors++;
                    $display("FAIL timeout_state: busy/ld_ready=%b want 00", {busy, ld_ready});
                end
            end
        end
        checks++;
        if ({busy, ld_ready} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_ready: busy/ld_ready=%b want 01", {busy, ld_ready});
        end
    endtask

    task automatic test_reset_mid_burst();
        wait_ready();
        load_and_burst(1'b0, 1'b0, -1, GAP + 2);
        wait_ready();
        load_and_burst(1'b0, 1'b0, -1, -1);
        do_results(NUM_OUT, -1);
    endtask

    initial begin
        test_reset();
        test_stray_load();
        test_back_to_back();
        test_toggle_load();
        test_timeout();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_stream_feeder.md
Name: conv_stream_feeder

Overview:
- Single-clock driver for the convolution engine's input interface, and consumer of its result stream.
- Buffers one pattern (ROWS image rows plus kernel words) loaded by a host over a valid/ready port.
- Replays the pattern to the engine as a contiguous in_valid burst, then collects NUM_OUT results from out_valid/out_data.
- Forwards each result with an index and reports completion or timeout. Sits in the clk1 domain beside the engine.

Parameters:
ROWS, 6, burst length in cycles; also buffer depth
ROW_W, 18, width of in_row (6 pixels x 3 bits)
KER_W, 12, width of in_kernel (2x2 kernel x 3 bits)
NUM_OUT, 150, results expected per pattern
GAP, 2, idle cycles (in_valid low) inserted before every burst; must be >= 1
TIMEOUT, 4096, max cycles allowed with no out_valid while waiting

Ports:
clk1  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
ld_valid  in  1  host load entry valid
ld_ready  out  1  feeder can accept a load entry
ld_row  in  ROW_W  image row for the entry
ld_kernel  in  KER_W  kernel word for the entry
in_valid  out  1  burst valid to engine
in_row  out  ROW_W  row to engine
in_kernel  out  KER_W  kernel to engine
out_valid  in  1  engine result valid
out_data  in  8  engine result
res_valid  out  1  forwarded result valid
res_data  out  8  forwarded result
res_idx  out  clog2(NUM_OUT)  0-based index of the forwarded result
done  out  1  one-cycle pulse: NUM_OUT results received
timeout  out  1  one-cycle pulse: pattern aborted by timeout
stray  out  1  one-cycle pulse: out_valid seen outside WAIT
busy  out  1  high in any state other than LOAD

Behaviour:
- Reset (async assert, sync release): state LOAD, all counters 0, every output 0 except ld_ready=1. Buffer contents are don't-care. Assertion mid-burst or mid-wait drops in_valid and res_valid on the reset edge.
- All outputs are registered. ld_ready is a state/counter decode with no ld_valid path.
- LOAD:
  - ld_ready=1.
  - Each ld_valid&ld_ready writes buffer[wcnt] and increments wcnt.
  - The ROWS-th accept at edge t moves to GAP, with ld_ready=0 from t+1.
- GAP: in_valid=0 for exactly GAP cycles, then SEND.
- SEND:
  - in_valid=1 for exactly ROWS consecutive cycles, carrying buffer[0..ROWS-1] in load order.
  - With the last load accepted at edge t, in_valid is high in cycles t+1+GAP through t+GAP+ROWS. Defaults give cycles t+3..t+8.
  - in_row and in_kernel are 0 whenever in_valid=0.
  - Then WAIT; rcnt and timer are cleared.
- WAIT:
  - Each sampled out_valid produces, next cycle: res_valid=1, res_data=out_data, res_idx=rcnt. rcnt then increments.
  - timer increments every cycle without out_valid and clears on out_valid.
  - The result with rcnt=NUM_OUT-1 is the last one. done pulses in the same cycle as its res_valid, and the state returns to LOAD; ld_ready=1 the following cycle.
  - timer reaching TIMEOUT-1 with no out_valid that cycle aborts the pattern: timeout pulses next cycle, state goes to LOAD, and results already forwarded stand.
  - out_valid and timeout expiry in the same cycle: the result wins and timer clears.
- out_valid in LOAD, GAP or SEND: ignored (not forwarded), and stray pulses next cycle.
- res_idx holds its last value when res_valid=0.
- No back-pressure on res_*: the consumer must accept every result.
- wcnt and rcnt never wrap; they are cleared on entering LOAD and WAIT respectively.
- busy = (state != LOAD).

Test Plan:
- Reset then load 6 entries back-to-back (ld_row=18'h00001..18'h00006, ld_kernel=12'h101..12'h106), last accepted at edge t -> in_valid high t+3..t+8 with rows 1..6 and kernels 101..106 in order; ld_ready=0 from t+1.
- Load with ld_valid toggling every other cycle -> exactly 6 accepts, burst data matches load order, no extra or missing rows.
- After a burst, drive 150 out_valid pulses, out_data=idx[7:0], with random gaps < TIMEOUT -> res_valid x150, res_idx 0..149, res_data matching, done pulse on idx 149, ld_ready=1 one cycle later.
- Drive 10 results then silence -> timeout pulse exactly TIMEOUT cycles after the 10th out_valid sample, state LOAD, no done.
- out_valid pulse during LOAD and during SEND -> stray pulse each, no res_valid, burst unaffected.
- Assert rst at the 3rd burst cycle -> in_valid=0 immediately, ld_ready=1, a subsequent full load/burst/150-result sequence completes normally.
